sgdma_descriptor_fetcher: RTL and testbench
===========================================

# sgdma_descriptor_fetcher

Chain-walking descriptor fetcher for the Ethernet scatter-gather DMA path. It reads 4-word descriptors from the 1024×32 single-port descriptor memory over an Avalon-MM master, hands each transfer to the DMA engine through a valid/ready command port, and waits for completion. It then writes the completion status back into the descriptor and follows the next pointer until the chain ends. NIOS II builds chains in descriptor memory and kicks the block with `start`/`start_ptr`.

## Interface
- `ADDR_W`, 10: descriptor memory word-address width; 1024 words.
- `clk` in 1: single clock for all logic.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle kick; ignored while `busy`=1.
- `start_ptr` in ADDR_W: word address of the first descriptor.
- `stop` in 1: level; requests a halt after the current descriptor.
- `busy` out 1: high from the cycle after `start` is accepted until return to IDLE.
- `irq` out 1: one-cycle pulse when a chain ends.
- `desc_address` out ADDR_W: memory word address.
- `desc_chipselect` out 1: memory access strobe.
- `desc_write` out 1: write strobe.
- `desc_byteenable` out 4: byte lanes; 4'hF on reads.
- `desc_writedata` out 32: write data.
- `desc_readdata` in 32: read data, valid the cycle after its address was presented (unregistered RAM output). `clocken` on the memory is tied high by the integrator.
- `cmd_valid` out 1: command to the DMA engine is valid.
- `cmd_ready` in 1: engine accepts the command.
- `cmd_src` out 32: source byte address.
- `cmd_dst` out 32: destination byte address.
- `cmd_len` out 16: length in bytes.
- `done_valid` in 1: one-cycle completion pulse from the engine.
- `done_status` in 8: engine status; bit 7 is reserved and must be 0.

## Operation
- Descriptor layout, relative to base P:
  - P+0: src.
  - P+1: dst.
  - P+2: next pointer (bits [ADDR_W-1:0]; 0 = end of chain).
  - P+3: control. [15:0] length, [23:16] status, [30:24] user flags (preserved), [31] OWNED (1 = hardware owns the descriptor).
- Address arithmetic is modulo 2^ADDR_W. A descriptor at 1022 reads words 1022, 1023, 0, 1.
- States: IDLE, FETCH, CHECK, CMD, WAIT, WB, NEXT.
- IDLE: outputs quiescent. When `start`=1, P <= `start_ptr` and the block goes to FETCH.
- FETCH: issues reads P+0..P+3 on 4 consecutive cycles (`desc_chipselect`=1, `desc_write`=0). Each word is captured one cycle after its address. The block goes to CHECK after the 4th capture.
- CHECK (1 cycle):
  - OWNED=0: chain end. Go to IDLE, pulse `irq`, no writeback.
  - OWNED=1 and length=0: skip the transfer. Go to WB with status 8'h80.
  - Otherwise: go to CMD.
- CMD: hold `cmd_valid`=1 with `cmd_src`, `cmd_dst` and `cmd_len` stable until `cmd_ready`=1, then go to WAIT. A transfer occurs on the cycle where valid&ready.
- WAIT: on `done_valid`=1, latch `done_status` and go to WB. A `done_valid` seen in any other state is ignored.
- WB: one write cycle to P+3.
  - `desc_byteenable`=4'b1100.
  - `desc_writedata` = {1'b0, flags[30:24], status, 16'h0000}.
  - This clears OWNED and writes status; length is untouched.
- NEXT (1 cycle):
  - `stop` sampled 1, or next pointer = 0: go to IDLE and pulse `irq`.
  - Otherwise P <= next pointer and go to FETCH.
- `stop` does not abort CMD, WAIT or WB. It takes effect only in NEXT, or in CHECK (same as OWNED=0). `stop` in IDLE has no effect.
- A self-loop (next = P) is legal. The walk ends when the rewritten OWNED=0 is read back.

## Timing
- Reset values (reset_n=0 at an edge): state IDLE.
  - `busy`, `irq`, `desc_chipselect`, `desc_write`, `cmd_valid` all 0.
  - `desc_address`, `desc_writedata`, `cmd_*` all 0.
  - `desc_byteenable` 4'hF.
- Reset mid-operation: next cycle is IDLE. No writeback is issued, and any write in flight on that edge is dropped.
- Cycle numbering: `start` is sampled high at edge 0.
  - Cycles 1–4: addresses P..P+3.
  - Cycles 2–5: data captured.
  - Cycle 6: CHECK.
  - Cycle 7: earliest `cmd_valid`.
- Completion: `done_valid` in cycle D gives a WB write in cycle D+1 and NEXT in D+2. FETCH of the next descriptor starts at D+3.
- `irq` is high for exactly the cycle after the terminating CHECK or NEXT. `busy` falls in that same cycle.
- All outputs are registered. There is no combinational path from `cmd_ready` or `done_valid` to any output.

## Test plan
- Single descriptor at 0x010: src=0x1000, dst=0x2000, len=64, next=0, OWNED=1, flags=0x05. Engine ready immediately; done_status=0x01. Required: one command (0x1000, 0x2000, 64); word 0x013 = 0x05010040; `irq` one pulse; `busy` low after it.
- Three-descriptor chain 0x020→0x030→0x040 with `cmd_ready` stalled 5 cycles on each. Required: three commands in order; every control word has OWNED=0 and its status; exactly one `irq`.
- Chain head with OWNED=0. Required: no `cmd_valid`; no writes; `irq` at cycle 7 after start.
- Zero-length descriptor in the middle of a chain. Required: no command for it; its status=0x80; walk continues.
- `stop` asserted during WAIT of descriptor 1 of 3. Required: descriptor 1 written back; no fetch of descriptor 2; `irq` pulses.
- Descriptor at 0x3FE plus `reset_n`=0 during WAIT. Required: reads 0x3FE, 0x3FF, 0x000, 0x001; after reset all outputs at reset values; memory word 0x001 unchanged.

Source files
------------

// File: rtl/sgdma_descriptor_fetcher_if.sv
// Bus bundle for the descriptor fetcher: NIOS control, descriptor-memory Avalon-MM master,
// and the DMA engine command/completion handshake.
interface sgdma_descriptor_fetcher_if #(
   parameter int ADDR_W = 10
);
   logic              start;
   logic [ADDR_W-1:0] start_ptr;
   logic              stop;
   logic              busy;
   logic              irq;

   logic [ADDR_W-1:0] desc_address;
   logic              desc_chipselect;
   logic              desc_write;
   logic [3:0]        desc_byteenable;
   logic [31:0]       desc_writedata;
   logic [31:0]       desc_readdata;

   logic              cmd_valid;
   logic              cmd_ready;
   logic [31:0]       cmd_src;
   logic [31:0]       cmd_dst;
   logic [15:0]       cmd_len;
   logic              done_valid;
   logic [7:0]        done_status;

   modport master (
      input  start, start_ptr, stop, desc_readdata, cmd_ready, done_valid, done_status,
      output busy, irq, desc_address, desc_chipselect, desc_write, desc_byteenable,
             desc_writedata, cmd_valid, cmd_src, cmd_dst, cmd_len
   );

   modport slave (
      output start, start_ptr, stop, desc_readdata, cmd_ready, done_valid, done_status,
      input  busy, irq, desc_address, desc_chipselect, desc_write, desc_byteenable,
             desc_writedata, cmd_valid, cmd_src, cmd_dst, cmd_len
   );
endinterface

// File: rtl/sgdma_descriptor_fetcher.sv
// Walks a linked chain of 4-word descriptors, issues one DMA command per descriptor,
// and writes the engine status back into each control word. All outputs are registered.
module sgdma_descriptor_fetcher #(
   parameter int ADDR_W = 10
) (
   input logic                        clk,
   input logic                        reset_n,
   sgdma_descriptor_fetcher_if.master bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_CHECK, S_CMD, S_WAIT, S_WB, S_NEXT
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [31:0]       src_q, src_d, dst_q, dst_d;
   logic [ADDR_W-1:0] next_q, next_d;
   logic [15:0]       len_q, len_d;
   logic [6:0]        flags_q, flags_d;
   logic              owned_q, owned_d;
   logic [7:0]        status_d;
   logic [2:0]        fetch_idx;

   logic              busy_q, busy_d, irq_q, irq_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              cs_q, cs_d, we_q, we_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              cmd_valid_q, cmd_valid_d;
   logic [31:0]       cmd_src_q, cmd_src_d, cmd_dst_q, cmd_dst_d;
   logic [15:0]       cmd_len_q, cmd_len_d;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         cnt_q       <= '0;
         src_q       <= '0;
         dst_q       <= '0;
         next_q      <= '0;
         len_q       <= '0;
         flags_q     <= '0;
         owned_q     <= 1'b0;
         busy_q      <= 1'b0;
         irq_q       <= 1'b0;
         addr_q      <= '0;
         cs_q        <= 1'b0;
         we_q        <= 1'b0;
         be_q        <= 4'hF;
         wdata_q     <= '0;
         cmd_valid_q <= 1'b0;
         cmd_src_q   <= '0;
         cmd_dst_q   <= '0;
         cmd_len_q   <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         src_q       <= src_d;
         dst_q       <= dst_d;
         next_q      <= next_d;
         len_q       <= len_d;
         flags_q     <= flags_d;
         owned_q     <= owned_d;
         busy_q      <= busy_d;
         irq_q       <= irq_d;
         addr_q      <= addr_d;
         cs_q        <= cs_d;
         we_q        <= we_d;
         be_q        <= be_d;
         wdata_q     <= wdata_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_src_q   <= cmd_src_d;
         cmd_dst_q   <= cmd_dst_d;
         cmd_len_q   <= cmd_len_d;
      end
   end

   // In FETCH, cnt_q counts cycles since the first address; word cnt_q-1 arrives on readdata.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      src_d    = src_q;
      dst_d    = dst_q;
      next_d   = next_q;
      len_d    = len_q;
      flags_d  = flags_q;
      owned_d  = owned_q;
      status_d = 8'h00;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               ptr_d   = bus.start_ptr;
               cnt_d   = '0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            cnt_d = cnt_q + 3'd1;
            case (cnt_q)
               3'd1: src_d = bus.desc_readdata;
               3'd2: dst_d = bus.desc_readdata;
               3'd3: next_d = bus.desc_readdata[ADDR_W-1:0];
               3'd4: begin
                  len_d   = bus.desc_readdata[15:0];
                  flags_d = bus.desc_readdata[30:24];
                  owned_d = bus.desc_readdata[31];
                  state_d = S_CHECK;
               end
               default: ;
            endcase
         end
         S_CHECK: begin
            if (!owned_q || bus.stop) begin
               state_d = S_IDLE;
            end else if (len_q == 16'h0000) begin
               status_d = 8'h80;
               state_d  = S_WB;
            end else begin
               state_d = S_CMD;
            end
         end
         S_CMD: begin
            if (bus.cmd_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bus.done_valid) begin
               status_d = bus.done_status;
               state_d  = S_WB;
            end
         end
         S_WB: state_d = S_NEXT;
         S_NEXT: begin
            if (bus.stop || next_q == '0) begin
               state_d = S_IDLE;
            end else begin
               ptr_d   = next_q;
               cnt_d   = '0;
               state_d = S_FETCH;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are the registered image of what the next state needs to present.
   always_comb begin
      busy_d      = (state_d != S_IDLE);
      irq_d       = (state_d == S_IDLE) && (state_q == S_CHECK || state_q == S_NEXT);
      addr_d      = addr_q;
      cs_d        = 1'b0;
      we_d        = 1'b0;
      be_d        = 4'hF;
      wdata_d     = wdata_q;
      cmd_valid_d = (state_d == S_CMD);
      cmd_src_d   = cmd_src_q;
      cmd_dst_d   = cmd_dst_q;
      cmd_len_d   = cmd_len_q;
      fetch_idx   = (state_q == S_FETCH) ? cnt_q + 3'd1 : 3'd0;

      if (state_d == S_FETCH && fetch_idx < 3'd4) begin
         cs_d   = 1'b1;
         addr_d = ptr_d + ADDR_W'(fetch_idx);
      end

      // Lanes 1:0 stay masked so the length field survives the status writeback.
      if (state_d == S_WB && state_q != S_WB) begin
         cs_d    = 1'b1;
         we_d    = 1'b1;
         be_d    = 4'b1100;
         addr_d  = ptr_q + ADDR_W'(3);
         wdata_d = {1'b0, flags_q, status_d, 16'h0000};
      end

      if (state_q == S_CHECK && state_d == S_CMD) begin
         cmd_src_d = src_q;
         cmd_dst_d = dst_q;
         cmd_len_d = len_q;
      end
   end

   assign bus.busy            = busy_q;
   assign bus.irq             = irq_q;
   assign bus.desc_address    = addr_q;
   assign bus.desc_chipselect = cs_q;
   assign bus.desc_write      = we_q;
   assign bus.desc_byteenable = be_q;
   assign bus.desc_writedata  = wdata_q;
   assign bus.cmd_valid       = cmd_valid_q;
   assign bus.cmd_src         = cmd_src_q;
   assign bus.cmd_dst         = cmd_dst_q;
   assign bus.cmd_len         = cmd_len_q;
endmodule

// File: tb/tb_sgdma_descriptor_fetcher.sv
// Bench for sgdma_descriptor_fetcher: descriptor RAM and DMA engine models, a chain-walking
// reference model, a directed vector table, hand sequences and randomized chains.
module tb_sgdma_descriptor_fetcher;
   localparam int ADDR_W = 10;
   localparam logic [159:0] RST_VEC = 160'({5'b0, 10'h000, 32'h0, 4'hF, 80'h0});

   typedef struct {
      string      name;
      logic [9:0] head;
      int         n;
      int         stall;
      int         zero_idx;
      logic       head_owned;
      int         stop_cmds;
      int         exp_cmds;
      int         exp_reads;
      int         exp_writes;
      int         exp_irq_cyc;
   } vec_t;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   sgdma_descriptor_fetcher_if #(.ADDR_W(ADDR_W)) bus ();
   sgdma_descriptor_fetcher #(.ADDR_W(ADDR_W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   logic [31:0] mem     [1024];
   logic [31:0] exp_mem [1024];
   logic [9:0]  rd_addr;
   logic [9:0]  read_log[$], write_log[$], exp_reads[$], exp_writes[$];
   logic [79:0] cmd_log[$], exp_cmds[$];
   int          checks = 0;
   int          errors = 0;
   int          stall_cfg = 0;
   int          done_delay = 2;

   assign bus.desc_readdata = mem[rd_addr];

   function automatic logic [7:0] engStatus(input int k);
      return 8'((k * 37 + 1) % 128);
   endfunction

   function automatic logic [159:0] outVec();
      return 160'({bus.busy, bus.irq, bus.desc_chipselect, bus.desc_write, bus.cmd_valid,
                   bus.desc_address, bus.desc_writedata, bus.desc_byteenable,
                   bus.cmd_src, bus.cmd_dst, bus.cmd_len});
   endfunction

   // Single-port RAM: address registered on the edge, data read combinationally from it.
   initial begin
      rd_addr <= '0;
      forever begin
         @(posedge clk);
         if (bus.desc_chipselect && !bus.desc_write) begin
            rd_addr <= bus.desc_address;
            read_log.push_back(bus.desc_address);
         end
         if (bus.desc_chipselect && bus.desc_write) begin
            for (int b = 0; b < 4; b++)
               if (bus.desc_byteenable[b]) mem[bus.desc_address][8*b +: 8] = bus.desc_writedata[8*b +: 8];
            write_log.push_back(bus.desc_address);
         end
      end
   end

   // DMA engine: stalls cmd_ready for stall_cfg cycles, completes done_delay cycles after accepting.
   initial begin
      int stall_left;
      int done_cnt;
      bus.cmd_ready   = 1'b0;
      bus.done_valid  = 1'b0;
      bus.done_status = 8'h00;
      stall_left = 0;
      done_cnt   = 0;
      forever begin
         @(negedge clk);
         bus.cmd_ready  = 1'b0;
         bus.done_valid = 1'b0;
         if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) begin
               bus.done_valid  = 1'b1;
               bus.done_status = engStatus(cmd_log.size() - 1);
            end
         end else if (bus.cmd_valid) begin
            if (stall_left < stall_cfg) stall_left++;
            else begin
               bus.cmd_ready = 1'b1;
               cmd_log.push_back({bus.cmd_src, bus.cmd_dst, bus.cmd_len});
               done_cnt   = done_delay;
               stall_left = 0;
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference walk over a copy of memory, following the descriptor rules directly.
   task automatic modelWalk(input logic [9:0] head, input int stop_after, input int cmd_base);
      logic [9:0]  p;
      logic [31:0] w [4];
      logic [7:0]  st;
      int          k;
      int          processed;
      p = head;
      k = cmd_base;
      processed = 0;
      exp_reads.delete();
      exp_writes.delete();
      exp_cmds.delete();
      for (int guard = 0; guard < 64; guard++) begin
         for (int i = 0; i < 4; i++) begin
            exp_reads.push_back(10'(p + 10'(i)));
            w[i] = exp_mem[10'(p + 10'(i))];
         end
         if (!w[3][31]) break;
         if (w[3][15:0] == 16'h0) st = 8'h80;
         else begin
            exp_cmds.push_back({w[0], w[1], w[3][15:0]});
            st = engStatus(k);
            k++;
         end
         exp_mem[10'(p + 10'd3)] = {1'b0, w[3][30:24], st, w[3][15:0]};
         exp_writes.push_back(10'(p + 10'd3));
         processed++;
         if (processed == stop_after || w[2][9:0] == 10'h0) break;
         p = w[2][9:0];
      end
   endtask

   task automatic applyStimulus(input logic [9:0] ptr, input int stop_cmds, output int first_cmd_cyc,
                                output int irq_cyc, output int irq_pulses, output logic busy1,
                                output logic busy_irq);
      int cyc;
      int since_irq;
      int cb;
      first_cmd_cyc = -1;
      irq_cyc = -1;
      irq_pulses = 0;
      busy1 = 1'b0;
      busy_irq = 1'b1;
      cb = cmd_log.size();
      @(negedge clk);
      bus.start     = 1'b1;
      bus.start_ptr = ptr;
      cyc = 0;
      since_irq = 0;
      while (cyc < 3000 && (irq_cyc < 0 || since_irq < 4)) begin
         @(negedge clk);
         cyc++;
         bus.start = 1'b0;
         if (cyc == 1) busy1 = bus.busy;
         if (bus.cmd_valid && first_cmd_cyc < 0) first_cmd_cyc = cyc;
         if (bus.irq) begin
            irq_pulses++;
            if (irq_cyc < 0) begin
               irq_cyc  = cyc;
               busy_irq = bus.busy;
            end
         end
         if (irq_cyc >= 0) since_irq++;
         if (stop_cmds > 0 && cmd_log.size() >= cb + stop_cmds) bus.stop = 1'b1;
      end
      bus.stop = 1'b0;
   endtask

   task automatic verifyRun(input string name, input int rb, input int wb, input int cb, input int pulses);
      int bad;
      checkOutput({name, " cmd_count"}, 160'(cmd_log.size() - cb), 160'(exp_cmds.size()));
      bad = 0;
      foreach (exp_cmds[i]) if (cb + i >= cmd_log.size() || cmd_log[cb + i] !== exp_cmds[i]) bad++;
      checkOutput({name, " cmd_fields_bad"}, 160'(bad), 160'(0));
      checkOutput({name, " read_count"}, 160'(read_log.size() - rb), 160'(exp_reads.size()));
      bad = 0;
      foreach (exp_reads[i]) if (rb + i >= read_log.size() || read_log[rb + i] !== exp_reads[i]) bad++;
      checkOutput({name, " read_addr_bad"}, 160'(bad), 160'(0));
      checkOutput({name, " write_count"}, 160'(write_log.size() - wb), 160'(exp_writes.size()));
      bad = 0;
      for (int i = 0; i < 1024; i++) if (mem[i] !== exp_mem[i]) bad++;
      checkOutput({name, " mem_words_bad"}, 160'(bad), 160'(0));
      checkOutput({name, " irq_pulses"}, 160'(pulses), 160'(1));
      checkOutput({name, " busy_after"}, 160'(bus.busy), 160'(0));
   endtask

   task automatic buildChain(input logic [9:0] head, input int n, input int zero_idx, input logic head_owned);
      for (int i = 0; i < n; i++) begin
         logic [9:0] p;
         p = 10'(head + 10'(16 * i));
         mem[p]             = 32'h1000_0000 + 32'(i * 256) + 32'(head);
         mem[10'(p + 10'd1)] = 32'h2000_0000 + 32'(i * 512) + 32'(head);
         mem[10'(p + 10'd2)] = (i < n - 1) ? {22'h0, 10'(p + 10'd16)} : 32'h0;
         mem[10'(p + 10'd3)] = {(i == 0) ? head_owned : 1'b1, 7'(i + 3), 8'hEE,
                                (i == zero_idx) ? 16'd0 : 16'(64 * (i + 1))};
      end
   endtask

   // Chain end styles: 0 = null next, 1 = self-loop on last, 2 = last descriptor not owned.
   task automatic randomChain(output logic [9:0] head);
      int         n, s0, stride, off, mode;
      logic [9:0] addr[$];
      n = $urandom_range(1, 5);
      s0 = $urandom_range(0, 60);
      stride = $urandom_range(1, 60);
      off = $urandom_range(0, 12);
      mode = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) addr.push_back(10'(16 * (1 + (s0 + i * stride) % 61) + off));
      for (int i = 0; i < n; i++) begin
         logic [9:0]  p, nx;
         logic [15:0] len;
         p = addr[i];
         if (i < n - 1) nx = addr[i + 1];
         else nx = (mode == 1) ? p : 10'd0;
         len = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
         mem[p]              = $urandom();
         mem[10'(p + 10'd1)] = $urandom();
         mem[10'(p + 10'd2)] = {22'($urandom()), nx};
         mem[10'(p + 10'd3)] = {(mode == 2 && i == n - 1) ? 1'b0 : 1'b1, 7'($urandom()), 8'($urandom()), len};
      end
      head = addr[0];
   endtask

   initial begin
      vec_t        vecs [4];
      int          fc, ic, ip, rb, wb, cb;
      logic        b1, bi;
      logic [9:0]  hd;
      logic [31:0] saved;
      logic [9:0]  wrap_exp [4];

      vecs[0] = '{"chain3_stall", 10'h020, 3, 5, -1, 1'b1, 0, 3, 12, 3, -1};
      vecs[1] = '{"head_unowned", 10'h050, 1, 0, -1, 1'b0, 0, 0, 4, 0, 7};
      vecs[2] = '{"zero_middle",  10'h100, 3, 1,  1, 1'b1, 0, 2, 12, 3, -1};
      vecs[3] = '{"stop_in_wait", 10'h200, 3, 0, -1, 1'b1, 1, 1, 4, 1, -1};

      bus.start = 1'b0;
      bus.start_ptr = '0;
      bus.stop = 1'b0;
      reset_n = 1'b0;
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      repeat (3) @(negedge clk);
      checkOutput("reset_outputs", outVec(), RST_VEC);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single descriptor with known values and exact cycle positions.
      mem[10'h010] = 32'h0000_1000;
      mem[10'h011] = 32'h0000_2000;
      mem[10'h012] = 32'h0;
      mem[10'h013] = {1'b1, 7'h05, 8'h00, 16'd64};
      stall_cfg = 0;
      done_delay = 3;
      rb = read_log.size(); wb = write_log.size(); cb = cmd_log.size();
      exp_mem = mem;
      modelWalk(10'h010, 0, cb);
      applyStimulus(10'h010, 0, fc, ic, ip, b1, bi);
      checkOutput("single first_cmd_cycle", 160'(fc), 160'(7));
      checkOutput("single irq_cycle", 160'(ic), 160'(13));
      checkOutput("single busy_cycle1", 160'(b1), 160'(1));
      checkOutput("single busy_at_irq", 160'(bi), 160'(0));
      checkOutput("single word_013", 160'(mem[10'h013]), 160'(32'h0501_0040));
      checkOutput("single cmd", (cmd_log.size() > cb) ? 160'(cmd_log[cb]) : 160'(0),
                  160'({32'h1000, 32'h2000, 16'd64}));
      verifyRun("single", rb, wb, cb, ip);

      for (int v = 0; v < 4; v++) begin
         buildChain(vecs[v].head, vecs[v].n, vecs[v].zero_idx, vecs[v].head_owned);
         stall_cfg = vecs[v].stall;
         done_delay = 4;
         rb = read_log.size(); wb = write_log.size(); cb = cmd_log.size();
         exp_mem = mem;
         modelWalk(vecs[v].head, vecs[v].stop_cmds, cb);
         applyStimulus(vecs[v].head, vecs[v].stop_cmds, fc, ic, ip, b1, bi);
         checkOutput({vecs[v].name, " tbl_cmds"}, 160'(cmd_log.size() - cb), 160'(vecs[v].exp_cmds));
         checkOutput({vecs[v].name, " tbl_reads"}, 160'(read_log.size() - rb), 160'(vecs[v].exp_reads));
         checkOutput({vecs[v].name, " tbl_writes"}, 160'(write_log.size() - wb), 160'(vecs[v].exp_writes));
         if (vecs[v].exp_irq_cyc > 0)
            checkOutput({vecs[v].name, " irq_cycle"}, 160'(ic), 160'(vecs[v].exp_irq_cyc));
         if (vecs[v].zero_idx >= 0)
            checkOutput({vecs[v].name, " zero_status"},
                        160'(mem[10'(vecs[v].head + 10'(16 * vecs[v].zero_idx + 3))][23:16]), 160'(8'h80));
         verifyRun(vecs[v].name, rb, wb, cb, ip);
      end

      for (int r = 0; r < 8; r++) begin
         randomChain(hd);
         stall_cfg = $urandom_range(0, 3);
         done_delay = $urandom_range(1, 4);
         rb = read_log.size(); wb = write_log.size(); cb = cmd_log.size();
         exp_mem = mem;
         modelWalk(hd, 0, cb);
         applyStimulus(hd, 0, fc, ic, ip, b1, bi);
         verifyRun($sformatf("random%0d", r), rb, wb, cb, ip);
      end

      // Descriptor straddling the top of memory, reset while waiting for completion.
      mem[10'h3FE] = 32'hAAAA_0000;
      mem[10'h3FF] = 32'hBBBB_0000;
      mem[10'h000] = 32'h0;
      mem[10'h001] = {1'b1, 7'h11, 8'h22, 16'd32};
      saved = mem[10'h001];
      stall_cfg = 0;
      done_delay = 20;
      rb = read_log.size(); wb = write_log.size(); cb = cmd_log.size();
      @(negedge clk);
      bus.start = 1'b1;
      bus.start_ptr = 10'h3FE;
      @(negedge clk);
      bus.start = 1'b0;
      for (int c = 0; c < 50 && cmd_log.size() == cb; c++) @(negedge clk);
      checkOutput("wrap cmd_accepted", 160'(cmd_log.size() - cb), 160'(1));
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      checkOutput("wrap reset_outputs", outVec(), RST_VEC);
      reset_n = 1'b1;
      repeat (30) @(negedge clk);
      wrap_exp = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
      checkOutput("wrap read_count", 160'(read_log.size() - rb), 160'(4));
      for (int i = 0; i < 4; i++)
         checkOutput($sformatf("wrap read%0d", i),
                     (rb + i < read_log.size()) ? 160'(read_log[rb + i]) : 160'(11'h7FF), 160'(wrap_exp[i]));
      checkOutput("wrap write_count", 160'(write_log.size() - wb), 160'(0));
      checkOutput("wrap word_001", 160'(mem[10'h001]), 160'(saved));
      checkOutput("wrap busy_after", 160'(bus.busy), 160'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
